// File: rtl/sel_nb_face_if.sv
// sel_nb_face_if -- button/lock inputs and face-selection outputs of the
// dice-launcher face-count selector.
// master: drives the buttons and Lock (board / roll generator side).
// slave : the selector itself.
interface sel_nb_face_if;
  logic       BTN_Up;
  logic       BTN_Down;
  logic       Lock;
  logic [6:0] NB_Face;
  logic [2:0] Face_Idx;
  logic       Sel_Chg;

  modport master (
    output BTN_Up,
    output BTN_Down,
    output Lock,
    input  NB_Face,
    input  Face_Idx,
    input  Sel_Chg
  );

  modport slave (
    input  BTN_Up,
    input  BTN_Down,
    input  Lock,
    output NB_Face,
    output Face_Idx,
    output Sel_Chg
  );
endinterface

// File: rtl/sel_nb_face.sv
// sel_nb_face -- face-count selector for the dice launcher.
// Synchronises and debounces the Up/Down buttons, steps a 3-bit index through
// the supported die sizes (4,6,8,10,12,20,30,100) with wrap-around and
// presents the registered face count. Selection is frozen while Lock is high.
// Optional feature: define SEL_FACE_AUTOREPEAT_EN to compile in hold-to-repeat.
module sel_nb_face #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned INIT_IDX        = 1
) (
  input logic          CLK,
  input logic          RST,
  sel_nb_face_if.slave bus
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

  // Index-to-face-count map; the only source of NB_Face values.
  function automatic logic [6:0] f_face_map(input logic [2:0] idx);
    logic [6:0] v;
    case (idx)
      3'd0:    v = 7'd4;
      3'd1:    v = 7'd6;
      3'd2:    v = 7'd8;
      3'd3:    v = 7'd10;
      3'd4:    v = 7'd12;
      3'd5:    v = 7'd20;
      3'd6:    v = 7'd30;
      3'd7:    v = 7'd100;
      default: v = 7'd4;
    endcase
    return v;
  endfunction

  // bit 0 = Up, bit 1 = Down throughout
  logic [1:0]    w_raw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_db;
  logic [1:0]    r_db_d;
  logic [DW-1:0] r_db_cnt [2];
  logic [1:0]    w_press;
  logic          w_up_ev;
  logic          w_dn_ev;
  logic          w_rpt_up;
  logic          w_rpt_dn;
  logic          w_up_step;
  logic          w_dn_step;
  logic [2:0]    w_next_idx;
  logic          w_chg;
  logic [2:0]    r_face_idx;
  logic [6:0]    r_nb_face;
  logic          r_sel_chg;

  assign w_raw = {bus.BTN_Down, bus.BTN_Up};

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debouncer: level flips only after the count reaches
  // DEBOUNCE_CYCLES with the synchronised level continuously different.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_db   <= 2'b00;
      r_db_d <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_db_cnt[i] <= {DW{1'b0}};
      end
    end else begin
      r_db_d <= r_db;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_db_cnt[i] == DW'(DEBOUNCE_CYCLES)) begin
            r_db[i]     <= r_sync2[i];
            r_db_cnt[i] <= {DW{1'b0}};
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
          end
        end else begin
          r_db_cnt[i] <= {DW{1'b0}};
        end
      end
    end
  end

  // Press events are rising edges of the debounced levels; Lock discards them.
  always_comb begin
    w_press = r_db & ~r_db_d;
    w_up_ev = w_press[0] & ~bus.Lock;
    w_dn_ev = w_press[1] & ~bus.Lock;
  end

`ifdef SEL_FACE_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  logic [RW-1:0] r_rpt_cnt;
  logic          r_rpt_act;
  logic          r_rpt_first;
  logic          w_one_held;
  logic          w_rpt_hit;

  // Repeat step fires when the running count hits the first delay, then the period.
  always_comb begin
    w_one_held = r_db[0] ^ r_db[1];
    if (r_rpt_first) begin
      w_rpt_hit = (r_rpt_cnt == RW'(REPEAT_DELAY));
    end else begin
      w_rpt_hit = (r_rpt_cnt == RW'(REPEAT_PERIOD));
    end
    w_rpt_up = r_rpt_act & w_one_held & ~bus.Lock & w_rpt_hit & r_db[0];
    w_rpt_dn = r_rpt_act & w_one_held & ~bus.Lock & w_rpt_hit & r_db[1];
  end

  // Repeat timer: armed by an accepted press, counts cycles since the last step,
  // and is cleared by release, both buttons, or Lock.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rpt_cnt   <= {RW{1'b0}};
      r_rpt_act   <= 1'b0;
      r_rpt_first <= 1'b0;
    end else if (!w_one_held || bus.Lock) begin
      r_rpt_cnt   <= {RW{1'b0}};
      r_rpt_act   <= 1'b0;
      r_rpt_first <= 1'b0;
    end else if (w_up_ev || w_dn_ev) begin
      r_rpt_cnt   <= RW'(1);
      r_rpt_act   <= 1'b1;
      r_rpt_first <= 1'b1;
    end else if (r_rpt_act) begin
      if (w_rpt_hit) begin
        r_rpt_cnt   <= RW'(1);
        r_rpt_first <= 1'b0;
      end else begin
        r_rpt_cnt <= r_rpt_cnt + RW'(1);
      end
    end else begin
      r_rpt_cnt <= r_rpt_cnt;
    end
  end
`else
  assign w_rpt_up = 1'b0;
  assign w_rpt_dn = 1'b0;
`endif

  // Next index: single-direction step with wrap; simultaneous Up/Down cancel.
  always_comb begin
    w_up_step  = w_up_ev | w_rpt_up;
    w_dn_step  = w_dn_ev | w_rpt_dn;
    w_next_idx = r_face_idx;
    w_chg      = 1'b0;
    if (w_up_step && !w_dn_step) begin
      w_next_idx = r_face_idx + 3'd1;
      w_chg      = 1'b1;
    end else if (w_dn_step && !w_up_step) begin
      w_next_idx = r_face_idx - 3'd1;
      w_chg      = 1'b1;
    end else begin
      w_next_idx = r_face_idx;
      w_chg      = 1'b0;
    end
  end

  // Output registers: index, mapped face count and change pulse move together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_face_idx <= 3'(INIT_IDX);
      r_nb_face  <= f_face_map(3'(INIT_IDX));
      r_sel_chg  <= 1'b0;
    end else begin
      r_face_idx <= w_next_idx;
      r_nb_face  <= f_face_map(w_next_idx);
      r_sel_chg  <= w_chg;
    end
  end

  assign bus.Face_Idx = r_face_idx;
  assign bus.NB_Face  = r_nb_face;
  assign bus.Sel_Chg  = r_sel_chg;

endmodule

// File: tb/tb_sel_nb_face.sv
// tb_sel_nb_face -- directed self-checking bench for sel_nb_face
// (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8).
module tb_sel_nb_face;

  logic clk;
  logic rst;
  int   cyc;
  int   chg_count;
  int   chg_t [0:63];
  int   n_vec;
  int   n_err;

  sel_nb_face_if bus ();

  sel_nb_face #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8),
    .INIT_IDX        (1)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edge counter
  always @(posedge clk) cyc <= cyc + 1;

  // record every Sel_Chg cycle, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.Sel_Chg === 1'b1) begin
      if (chg_count < 64) chg_t[chg_count] = cyc;
      chg_count = chg_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // raise buttons just after an edge; c0 = edge count at that moment
  task automatic press(input logic up, input logic dn, output int c0, output int n0);
    tick();
    n0 = chg_count;
    c0 = cyc;
    bus.BTN_Up   = up;
    bus.BTN_Down = dn;
    repeat (10) tick();
  endtask

  task automatic release_all();
    bus.BTN_Up   = 1'b0;
    bus.BTN_Down = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_vec++; if (bus.Face_Idx !== 3'd1) begin n_err++; $display("FAIL reset_idx got %0d exp 1", bus.Face_Idx); end
    n_vec++; if (bus.NB_Face !== 7'd6) begin n_err++; $display("FAIL reset_nb got %0d exp 6", bus.NB_Face); end
    rst = 1'b0;
    chg_count = 0;
    repeat (20) tick();
    n_vec++; if (bus.Face_Idx !== 3'd1) begin n_err++; $display("FAIL idle_idx got %0d exp 1", bus.Face_Idx); end
    n_vec++; if (bus.NB_Face !== 7'd6) begin n_err++; $display("FAIL idle_nb got %0d exp 6", bus.NB_Face); end
    n_vec++; if (chg_count !== 0) begin n_err++; $display("FAIL idle_selchg got %0d exp 0", chg_count); end
  endtask

  task automatic test_up_sequence();
    logic [6:0] exp_nb [8];
    logic [2:0] exp_idx [8];
    int c0, n0;
    exp_nb  = '{7'd8, 7'd10, 7'd12, 7'd20, 7'd30, 7'd100, 7'd4, 7'd6};
    exp_idx = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    for (int i = 0; i < 8; i++) begin
      press(1'b1, 1'b0, c0, n0);
      n_vec++; if (chg_count !== n0 + 1) begin n_err++; $display("FAIL up%0d_pulses got %0d exp %0d", i, chg_count - n0, 1); end
      n_vec++; if (chg_t[n0] !== c0 + 8) begin n_err++; $display("FAIL up%0d_latency got %0d exp %0d", i, chg_t[n0] - c0, 8); end
      n_vec++; if (bus.NB_Face !== exp_nb[i]) begin n_err++; $display("FAIL up%0d_nb got %0d exp %0d", i, bus.NB_Face, exp_nb[i]); end
      n_vec++; if (bus.Face_Idx !== exp_idx[i]) begin n_err++; $display("FAIL up%0d_idx got %0d exp %0d", i, bus.Face_Idx, exp_idx[i]); end
      release_all();
      n_vec++; if (chg_count !== n0 + 1) begin n_err++; $display("FAIL up%0d_release got %0d exp %0d", i, chg_count - n0, 1); end
    end
  endtask

  task automatic test_down_wrap();
    int c0, n0;
    press(1'b0, 1'b1, c0, n0);
    n_vec++; if (bus.NB_Face !== 7'd4) begin n_err++; $display("FAIL down1_nb got %0d exp 4", bus.NB_Face); end
    n_vec++; if (chg_t[n0] !== c0 + 8) begin n_err++; $display("FAIL down1_latency got %0d exp 8", chg_t[n0] - c0); end
    release_all();
    press(1'b0, 1'b1, c0, n0);
    n_vec++; if (bus.Face_Idx !== 3'd7) begin n_err++; $display("FAIL down_wrap_idx got %0d exp 7", bus.Face_Idx); end
    n_vec++; if (bus.NB_Face !== 7'd100) begin n_err++; $display("FAIL down_wrap_nb got %0d exp 100", bus.NB_Face); end
    n_vec++; if (chg_count !== n0 + 1) begin n_err++; $display("FAIL down_wrap_pulses got %0d exp 1", chg_count - n0); end
    release_all();
  endtask

  task automatic test_bounce();
    logic pat [8];
    int c0, n0;
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tick();
    n0 = chg_count;
    for (int i = 0; i < 8; i++) begin
      bus.BTN_Up = pat[i];
      tick();
    end
    c0 = cyc;
    bus.BTN_Up = 1'b1;
    repeat (12) tick();
    n_vec++; if (chg_count !== n0 + 1) begin n_err++; $display("FAIL bounce_pulses got %0d exp 1", chg_count - n0); end
    n_vec++; if (chg_t[n0] !== c0 + 8) begin n_err++; $display("FAIL bounce_latency got %0d exp 8", chg_t[n0] - c0); end
    n_vec++; if (bus.NB_Face !== 7'd4) begin n_err++; $display("FAIL bounce_nb got %0d exp 4", bus.NB_Face); end
    release_all();
  endtask

  task automatic test_lock();
    int c0, n0;
    bus.Lock = 1'b1;
    press(1'b1, 1'b0, c0, n0);
    bus.Lock = 1'b0;
    repeat (10) tick();
    release_all();
    n_vec++; if (chg_count !== n0) begin n_err++; $display("FAIL lock_pulses got %0d exp 0", chg_count - n0); end
    n_vec++; if (bus.Face_Idx !== 3'd0) begin n_err++; $display("FAIL lock_idx got %0d exp 0", bus.Face_Idx); end
  endtask

  task automatic test_both();
    int c0, n0;
    press(1'b1, 1'b1, c0, n0);
    release_all();
    n_vec++; if (chg_count !== n0) begin n_err++; $display("FAIL both_pulses got %0d exp 0", chg_count - n0); end
    n_vec++; if (bus.NB_Face !== 7'd4) begin n_err++; $display("FAIL both_nb got %0d exp 4", bus.NB_Face); end
  endtask

  task automatic test_autorepeat();
    int c0, n0;
`ifdef SEL_FACE_AUTOREPEAT_EN
    int offs [6];
    offs = '{8, 28, 36, 44, 52, 60};
`endif
    tick();
    n0 = chg_count;
    c0 = cyc;
    bus.BTN_Up = 1'b1;
    repeat (60) tick();
    release_all();
    repeat (5) tick();
`ifdef SEL_FACE_AUTOREPEAT_EN
    n_vec++; if (chg_count !== n0 + 6) begin n_err++; $display("FAIL rpt_steps got %0d exp 6", chg_count - n0); end
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (chg_t[n0 + i] !== c0 + offs[i]) begin n_err++; $display("FAIL rpt_t%0d got %0d exp %0d", i, chg_t[n0 + i] - c0, offs[i]); end
    end
    n_vec++; if (bus.NB_Face !== 7'd30) begin n_err++; $display("FAIL rpt_nb got %0d exp 30", bus.NB_Face); end
`else
    n_vec++; if (chg_count !== n0 + 1) begin n_err++; $display("FAIL hold_steps got %0d exp 1", chg_count - n0); end
    n_vec++; if (chg_t[n0] !== c0 + 8) begin n_err++; $display("FAIL hold_latency got %0d exp 8", chg_t[n0] - c0); end
    n_vec++; if (bus.NB_Face !== 7'd6) begin n_err++; $display("FAIL hold_nb got %0d exp 6", bus.NB_Face); end
`endif
  endtask

  task automatic test_reset_mid();
    int n0;
    tick();
    n0 = chg_count;
    bus.BTN_Up = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (bus.Face_Idx !== 3'd1) begin n_err++; $display("FAIL rstmid_idx got %0d exp 1", bus.Face_Idx); end
    n_vec++; if (chg_count !== n0) begin n_err++; $display("FAIL rstmid_nostep got %0d exp 0", chg_count - n0); end
    repeat (15) tick();
    n_vec++; if (chg_count !== n0 + 1) begin n_err++; $display("FAIL rstheld_pulses got %0d exp 1", chg_count - n0); end
    n_vec++; if (bus.NB_Face !== 7'd8) begin n_err++; $display("FAIL rstheld_nb got %0d exp 8", bus.NB_Face); end
    release_all();
  endtask

  initial begin
    cyc          = 0;
    chg_count    = 0;
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b1;
    bus.BTN_Up   = 1'b0;
    bus.BTN_Down = 1'b0;
    bus.Lock     = 1'b0;
    test_reset();
    test_up_sequence();
    test_down_wrap();
    test_bounce();
    test_lock();
    test_both();
    test_autorepeat();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
